cd_llc_node: RTL and testbench

LLC-side endpoint of the CD-mesh global crossbar. Accepts request packets on one LLC request port, queues them, services reads and writes against a local 256x16 storage array after a fixed service latency, and returns one reply packet per request on the matching LLC reply port. The reply header keeps the requester's source coordinates, which the crossbar reply path uses to route it back. One instance per LLC slice, four per mesh.

---
 rtl/cd_pkt_pkg.sv | 55 +++++
 rtl/cd_llc_req_fifo.sv | 60 ++++++
 rtl/cd_llc_node.sv | 157 +++++++++++++++
 tb/tb_cd_llc_node.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_pkt_pkg.sv
// Shared CD-mesh packet definitions: field positions, op encodings,
// reply marker bit, LLC service FSM encoding and the reply builder.
package cd_pkt_pkg;

  localparam int PKT_W     = 64;

  // Header field positions
  localparam int VC_BIT    = 63;
  localparam int DX_BIT    = 62;
  localparam int DY_BIT    = 61;
  localparam int RSV_MSB   = 60;
  localparam int RSV_LSB   = 56;
  localparam int OP_BIT    = 56;  // rsv[0]
  localparam int REPLY_BIT = 57;  // rsv[1]
  localparam int HX_MSB    = 55;
  localparam int HX_LSB    = 52;
  localparam int HY_MSB    = 51;
  localparam int HY_LSB    = 48;
  localparam int SRCX_MSB  = 47;
  localparam int SRCX_LSB  = 40;
  localparam int SRCY_MSB  = 39;
  localparam int SRCY_LSB  = 32;

  // Payload field positions
  localparam int ADDR_MSB  = 31;
  localparam int ADDR_LSB  = 24;
  localparam int PAD_MSB   = 23;
  localparam int PAD_LSB   = 16;
  localparam int DATA_MSB  = 15;
  localparam int DATA_LSB  = 0;

  // Operation encodings carried in rsv[0]
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // LLC service FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } llc_state_t;

  // Reply = request header with the reply marker set, address kept,
  // pad byte cleared and the data field replaced by the returned data.
  function automatic logic [PKT_W-1:0] build_reply(input logic [PKT_W-1:0] req,
                                                   input logic [15:0]      data);
    logic [PKT_W-1:0] rep;
    rep                     = req;
    rep[REPLY_BIT]          = 1'b1;
    rep[PAD_MSB:PAD_LSB]    = 8'h00;
    rep[DATA_MSB:DATA_LSB]  = data;
    return rep;
  endfunction

endpackage

// File: rtl/cd_llc_req_fifo.sv
// Parameterised synchronous FIFO with registered storage. Pointers carry
// one extra wrap bit so full and empty are told apart. Push while full and
// pop while empty are ignored. Ready is not passed through a same-cycle pop.
module cd_llc_req_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cd_llc_req_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = store[rd_ptr[AW-1:0]];

  // Advance write/read pointers; both may move in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cd_llc_node.sv
// LLC-side endpoint of the CD-mesh crossbar: queues requests, services
// reads/writes against a 256x16 array after SRV_LAT wait cycles and returns
// one reply per request, in order, carrying the requester's coordinates.
// Optional feature macro: CD_LLC_MISROUTE_CHK_EN (drop and count requests
// whose hx[1:0] does not match LLC_ID).
module cd_llc_node
  import cd_pkt_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int LLC_ID     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int SRV_LAT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_si,
  output logic              req_ri,
  input  logic [DATA_W-1:0] req_di,
  output logic              rep_so,
  input  logic              rep_ro,
  output logic [DATA_W-1:0] rep_do,
  output logic [7:0]        err_cnt
);

  localparam int CNT_W = $clog2(SRV_LAT + 1);

  generate
    if (DATA_W != PKT_W || LLC_ID < 0 || LLC_ID > 3 || SRV_LAT < 1) begin : g_bad_param
      $error("cd_llc_node: unsupported parameter combination");
    end
  endgenerate

  llc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [PKT_W-1:0]  work;
  logic [15:0]       mem [256];
  logic [255:0]      mem_vld;

  logic              push;
  logic              pop;
  logic [PKT_W-1:0]  fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  logic [7:0]        addr;
  logic [15:0]       wdata;
  logic              is_wr;
  logic [15:0]       rd_data;
  logic              svc;
  logic              mem_we;

  cd_llc_req_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (req_di),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign req_ri = ~fifo_full;
  assign pop    = (state == ST_IDLE) && !fifo_empty;

`ifdef CD_LLC_MISROUTE_CHK_EN
  localparam logic [1:0] LLC_ID_L = 2'(LLC_ID);

  logic       misroute;
  logic [7:0] err_q;

  assign misroute = (req_di[HX_LSB+1:HX_LSB] != LLC_ID_L);
  assign push     = req_si & req_ri & ~misroute;
  assign err_cnt  = err_q;

  // Count misrouted requests swallowed at the handshake, saturating at 255.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 8'd0;
    end else if (req_si && req_ri && misroute && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end
`else
  assign push    = req_si & req_ri;
  assign err_cnt = 8'd0;
`endif

  // Work-register decode and the access that completes on the last WAIT cycle.
  assign addr    = work[ADDR_MSB:ADDR_LSB];
  assign wdata   = work[DATA_MSB:DATA_LSB];
  assign is_wr   = (work[OP_BIT] == OP_WRITE);
  assign svc     = (state == ST_WAIT) && (cnt == CNT_W'(1));
  assign mem_we  = svc && is_wr;
  // Locations never written since reset read as zero.
  assign rd_data = mem_vld[addr] ? mem[addr] : 16'h0000;

  // Service FSM: pop into the work register, wait SRV_LAT cycles, then hold
  // the reply until the crossbar takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= {CNT_W{1'b0}};
      work   <= {PKT_W{1'b0}};
      rep_so <= 1'b0;
      rep_do <= {DATA_W{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            work  <= fifo_dout;
            cnt   <= CNT_W'(SRV_LAT);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (svc) begin
            rep_do <= build_reply(work, is_wr ? wdata : rd_data);
            rep_so <= 1'b1;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rep_ro) begin
            rep_so <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          rep_so <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-location written flags; clearing these clears the array on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_vld <= 256'd0;
    end else if (mem_we) begin
      mem_vld[addr] <= 1'b1;
    end
  end

  // Storage array data; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: tb/tb_cd_llc_node.sv
// Self-checking bench for cd_llc_node. Expected replies come from a
// request-level model: each accepted request updates a model memory and
// appends its reply to an in-order queue.
module tb_cd_llc_node;

  localparam int         SRV_LAT = 2;
  localparam int         DEPTH   = 4;
  localparam logic [1:0] MY_ID   = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_si;
  logic        req_ri;
  logic [63:0] req_di;
  logic        rep_so;
  logic        rep_ro;
  logic [63:0] rep_do;
  logic [7:0]  err_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [15:0] mdl_mem [256];
  logic [63:0] exp_q [$];
  int          mdl_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cd_llc_node #(
    .DATA_W     (64),
    .LLC_ID     (2),
    .FIFO_DEPTH (DEPTH),
    .SRV_LAT    (SRV_LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_si  (req_si),
    .req_ri  (req_ri),
    .req_di  (req_di),
    .rep_so  (rep_so),
    .rep_ro  (rep_ro),
    .rep_do  (rep_do),
    .err_cnt (err_cnt)
  );

  function automatic logic [63:0] mk_req(input logic wr, input logic [3:0] hx,
                                         input logic [7:0] sx, input logic [7:0] sy,
                                         input logic [7:0] addr, input logic [15:0] d);
    logic [2:0] vdd;
    logic [2:0] rsv_hi;
    logic [3:0] hy;
    logic [7:0] pad;
    vdd    = 3'($urandom);
    rsv_hi = 3'($urandom);
    hy     = 4'($urandom);
    pad    = 8'($urandom);
    return {vdd, rsv_hi, 1'b0, wr, hx, hy, sx, sy, addr, pad, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 16'h0000;
    exp_q.delete();
    mdl_err = 0;
  endtask

  task automatic model_accept(input logic [63:0] p);
    logic [7:0]  a;
    logic [15:0] d;
    logic [3:0]  hx;
    a  = p[31:24];
    d  = p[15:0];
    hx = p[55:52];
`ifdef CD_LLC_MISROUTE_CHK_EN
    if (hx[1:0] != MY_ID) begin
      if (mdl_err < 255) mdl_err++;
      return;
    end
`endif
    if (p[56]) begin
      mdl_mem[a] = d;
    end else begin
      d = mdl_mem[a];
    end
    exp_q.push_back({p[63:58], 1'b1, p[56:24], 8'h00, d});
  endtask

  // Present p until accepted (bounded); returns the cycle of the handshake.
  task automatic send(input logic [63:0] p, output bit ok, output int acc);
    ok = 1'b0;
    acc = -1;
    req_di = p;
    req_si = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (req_ri === 1'b1) begin
        acc = cyc;
        ok = 1'b1;
        model_accept(p);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_si = 1'b0;
  endtask

  // Accept one reply (bounded); returns it and the first cycle it was valid.
  task automatic recv(output logic [63:0] p, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    p = 64'd0;
    rep_ro = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rep_so === 1'b1) begin
        p = rep_do;
        at = cyc;
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    rep_ro = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req_si = 1'b0;
    rep_ro = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [63:0] next_exp();
    if (exp_q.size() == 0) return 64'hxxxx_xxxx_xxxx_xxxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    checks++; if (req_ri !== 1'b1) begin failures++; $display("FAIL reset_req_ri: got %b want 1", req_ri); end
    checks++; if (rep_so !== 1'b0) begin failures++; $display("FAIL reset_rep_so: got %b want 0", rep_so); end
    checks++; if (rep_do !== 64'd0) begin failures++; $display("FAIL reset_rep_do: got %h want 0", rep_do); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_write_read();
    logic [63:0] p, r, e;
    bit ok;
    int acc, at;
    p = mk_req(1'b1, {2'b00, MY_ID}, 8'd1, 8'd2, 8'h10, 16'hBEEF);
    send(p, ok, acc);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wr_accept: got %b want 1", ok); end
    recv(r, ok, at);
    e = next_exp();
    checks++; if (at !== acc + SRV_LAT + 2) begin failures++; $display("FAIL wr_latency: got %0d want %0d", at - acc, SRV_LAT + 2); end
    checks++; if (r[15:0] !== 16'hBEEF) begin failures++; $display("FAIL wr_echo: got %h want beef", r[15:0]); end
    checks++; if (r[47:32] !== 16'h0102 || r[57] !== 1'b1) begin failures++; $display("FAIL wr_hdr: got src %h rsv1 %b want 0102 1", r[47:32], r[57]); end
    checks++; if (r !== e) begin failures++; $display("FAIL wr_reply: got %h want %h", r, e); end
    p = mk_req(1'b0, {2'b00, MY_ID}, 8'd1, 8'd2, 8'h10, 16'h5A5A);
    send(p, ok, acc);
    recv(r, ok, at);
    e = next_exp();
    checks++; if (at !== acc + SRV_LAT + 2) begin failures++; $display("FAIL rd_latency: got %0d want %0d", at - acc, SRV_LAT + 2); end
    checks++; if (r[15:0] !== 16'hBEEF) begin failures++; $display("FAIL rd_data: got %h want beef", r[15:0]); end
    checks++; if (r[47:32] !== 16'h0102 || r[57] !== 1'b1) begin failures++; $display("FAIL rd_hdr: got src %h rsv1 %b want 0102 1", r[47:32], r[57]); end
    checks++; if (r !== e) begin failures++; $display("FAIL rd_reply: got %h want %h", r, e); end
  endtask

  task automatic test_backpressure();
    logic [63:0] p, r, e, held, pf;
    bit ok, okf;
    int acc, accf, at, prev_at, n_ok, bad;
    rep_ro = 1'b0;
    p = mk_req(1'($urandom), {2'($urandom), MY_ID}, 8'd3, 8'd4, 8'($urandom_range(0, 7)), 16'($urandom));
    send(p, ok, acc);
    for (int i = 0; i < 20 && rep_so !== 1'b1; i++) @(negedge clk);
    checks++; if (rep_so !== 1'b1) begin failures++; $display("FAIL bp_first_valid: got %b want 1", rep_so); end
    held = rep_do;
    n_ok = 0;
    for (int k = 0; k < DEPTH; k++) begin
      p = mk_req(1'($urandom), {2'($urandom), MY_ID}, 8'(k), 8'd9, 8'($urandom_range(0, 7)), 16'($urandom));
      send(p, ok, acc);
      if (ok) n_ok++;
    end
    checks++; if (n_ok !== DEPTH) begin failures++; $display("FAIL bp_fill: got %0d accepted want %0d", n_ok, DEPTH); end
    checks++; if (req_ri !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", req_ri); end
    pf = mk_req(1'b0, {2'b11, MY_ID}, 8'd7, 8'd7, 8'($urandom_range(0, 7)), 16'd0);
    fork
      send(pf, okf, accf);
      begin
        bad = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (rep_so !== 1'b1 || rep_do !== held || req_ri !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        prev_at = -1;
        for (int k = 0; k < DEPTH + 2; k++) begin
          recv(r, ok, at);
          e = next_exp();
          checks++; if (ok !== 1'b1 || r !== e) begin failures++; $display("FAIL bp_drain%0d: got %h want %h", k, r, e); end
          if (k > 0) begin
            checks++; if (at - prev_at !== SRV_LAT + 2) begin failures++; $display("FAIL bp_spacing%0d: got %0d want %0d", k, at - prev_at, SRV_LAT + 2); end
          end
          prev_at = at;
        end
      end
    join
    checks++; if (okf !== 1'b1) begin failures++; $display("FAIL bp_fifth_accept: got %b want 1", okf); end
  endtask

  task automatic test_read_after_reset();
    logic [63:0] p, r, e;
    bit ok;
    int acc, at;
    p = mk_req(1'b1, {2'b00, MY_ID}, 8'd5, 8'd6, 8'hFF, 16'h1234);
    send(p, ok, acc);
    recv(r, ok, at);
    e = next_exp();
    checks++; if (r !== e) begin failures++; $display("FAIL rar_write: got %h want %h", r, e); end
    pulse_reset();
    checks++; if (rep_so !== 1'b0) begin failures++; $display("FAIL rar_rep_so: got %b want 0", rep_so); end
    p = mk_req(1'b0, {2'b00, MY_ID}, 8'd5, 8'd6, 8'hFF, 16'hFFFF);
    send(p, ok, acc);
    recv(r, ok, at);
    e = next_exp();
    checks++; if (r[15:0] !== 16'h0000) begin failures++; $display("FAIL rar_data: got %h want 0000", r[15:0]); end
    checks++; if (r !== e) begin failures++; $display("FAIL rar_reply: got %h want %h", r, e); end
  endtask

  task automatic test_reset_mid_resp();
    logic [63:0] p;
    bit ok;
    int acc, seen;
    rep_ro = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p = mk_req(1'($urandom), {2'b01, MY_ID}, 8'd8, 8'(k), 8'($urandom_range(0, 7)), 16'($urandom));
      send(p, ok, acc);
    end
    for (int i = 0; i < 20 && rep_so !== 1'b1; i++) @(negedge clk);
    checks++; if (rep_so !== 1'b1) begin failures++; $display("FAIL rmr_in_resp: got %b want 1", rep_so); end
    pulse_reset();
    checks++; if (rep_so !== 1'b0) begin failures++; $display("FAIL rmr_rep_so: got %b want 0", rep_so); end
    checks++; if (req_ri !== 1'b1) begin failures++; $display("FAIL rmr_req_ri: got %b want 1", req_ri); end
    rep_ro = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rep_so !== 1'b0) seen++;
    end
    rep_ro = 1'b0;
    checks++; if (seen !== 0) begin failures++; $display("FAIL rmr_no_reply: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_misroute();
    logic [63:0] p, r, e;
    bit ok;
    int acc, at, seen;
`ifdef CD_LLC_MISROUTE_CHK_EN
    p = mk_req(1'b1, 4'b0001, 8'd2, 8'd2, 8'h20, 16'hDEAD);
    send(p, ok, acc);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mr_accept: got %b want 1", ok); end
    rep_ro = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rep_so !== 1'b0) seen++;
    end
    rep_ro = 1'b0;
    checks++; if (seen !== 0) begin failures++; $display("FAIL mr_no_reply: got %0d valid cycles want 0", seen); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL mr_err_cnt: got %0d want 1", err_cnt); end
    p = mk_req(1'b0, 4'b0110, 8'd2, 8'd2, 8'h20, 16'h0000);
    send(p, ok, acc);
    recv(r, ok, at);
    e = next_exp();
    checks++; if (r !== e || r[15:0] !== 16'h0000) begin failures++; $display("FAIL mr_good_reply: got %h want %h", r, e); end
    for (int k = 0; k < 260; k++) begin
      p = mk_req(1'b1, {2'($urandom), 2'b00}, 8'd1, 8'd1, 8'h30, 16'hFFFF);
      send(p, ok, acc);
    end
    @(negedge clk);
    checks++; if (err_cnt !== 8'(mdl_err) || err_cnt !== 8'd255) begin failures++; $display("FAIL mr_saturate: got %0d want %0d", err_cnt, mdl_err); end
    checks++; if (rep_so !== 1'b0) begin failures++; $display("FAIL mr_sat_no_reply: got %b want 0", rep_so); end
`else
    p = mk_req(1'b1, 4'b0001, 8'd2, 8'd2, 8'h20, 16'hDEAD);
    send(p, ok, acc);
    recv(r, ok, at);
    e = next_exp();
    checks++; if (ok !== 1'b1 || r !== e) begin failures++; $display("FAIL nomr_reply: got %h want %h", r, e); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL nomr_err_cnt: got %0d want 0", err_cnt); end
    seen = 0;
`endif
  endtask

  task automatic test_random();
    logic [63:0] p, r, e;
    bit ok;
    int acc, at, n;
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(1, DEPTH + 1);
      rep_ro = 1'b0;
      for (int j = 0; j < n; j++) begin
        p = mk_req(1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom_range(0, 7)), 16'($urandom));
        send(p, ok, acc);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rnd_accept%0d_%0d: got %b want 1", b, j, ok); end
      end
      while (exp_q.size() > 0) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        recv(r, ok, at);
        e = next_exp();
        checks++; if (ok !== 1'b1 || r !== e) begin failures++; $display("FAIL rnd_reply%0d: got %h want %h", b, r, e); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    req_si = 1'b0;
    rep_ro = 1'b0;
    req_di = 64'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_read_after_reset();
    test_reset_mid_resp();
    test_misroute();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
